// File: rtl/nts_rx_buffer.sv
// Single-packet receive buffer: captures one MAC frame into RAM, judges it from the
// end-of-frame strobes and presents it to the engine as a first-word-fall-through FIFO.
module nts_rx_buffer #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        i_clk,
  input  logic        i_areset,
  input  logic [7:0]  i_mac_rx_data_valid,
  input  logic [63:0] i_mac_rx_data,
  input  logic        i_mac_rx_good,
  input  logic        i_mac_rx_bad,
  output logic        o_dispatch_packet_available,
  input  logic        i_dispatch_packet_read_discard,
  output logic [7:0]  o_dispatch_data_valid,
  output logic        o_dispatch_fifo_empty,
  input  logic        i_dispatch_fifo_rd_en,
  output logic [63:0] o_dispatch_fifo_rd_data,
  output logic [31:0] o_dropped_packets
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_WRITE,
    S_LOAD,
    S_AVAILABLE
  } state_t;

  localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state, state_d;
  logic                  skip, skip_d;
  logic [31:0]           counter;
  logic                  drop;
  logic [ADDR_WIDTH:0]   count, count_d;
  logic [ADDR_WIDTH:0]   rd_ptr, rd_ptr_d, rd_ptr_inc;
  logic [7:0]            last_mask, last_mask_d;
  logic [63:0]           rd_data;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [63:0]           mem [2**ADDR_WIDTH];

  logic beat, strobe, mask_ok;
  logic [ADDR_WIDTH+1:0] rd_next;

  // Legal masks are contiguous ones from bit 0: m+1 clears every set bit.
  function automatic logic mask_legal(input logic [7:0] m);
    return (m != 8'h00) && ((m & (m + 8'd1)) == 8'h00);
  endfunction

  assign beat       = |i_mac_rx_data_valid;
  assign strobe     = i_mac_rx_good | i_mac_rx_bad;
  assign mask_ok    = mask_legal(i_mac_rx_data_valid);
  assign rd_ptr_inc = rd_ptr + 1'b1;

  always_comb begin
    state_d     = state;
    skip_d      = skip;
    count_d     = count;
    last_mask_d = last_mask;
    rd_ptr_d    = rd_ptr;
    drop        = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = count[ADDR_WIDTH-1:0];
    mem_re      = 1'b0;
    mem_raddr   = rd_ptr_inc[ADDR_WIDTH-1:0];

    // Beat handling first; strobe handling below sees the post-beat state.
    unique case (state)
      S_EMPTY: begin
        if (beat && !skip) begin
          if (mask_ok) begin
            mem_we      = 1'b1;
            mem_waddr   = '0;
            count_d     = {{ADDR_WIDTH{1'b0}}, 1'b1};
            last_mask_d = i_mac_rx_data_valid;
            state_d     = S_WRITE;
          end else begin
            skip_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (beat) begin
          if (count == CAPACITY || last_mask != 8'hff || !mask_ok) begin
            state_d = S_EMPTY;
            skip_d  = 1'b1;
          end else begin
            mem_we      = 1'b1;
            count_d     = count + 1'b1;
            last_mask_d = i_mac_rx_data_valid;
          end
        end
      end
      S_LOAD: begin
        mem_re    = 1'b1;
        mem_raddr = '0;
        rd_ptr_d  = '0;
        state_d   = S_AVAILABLE;
        if (beat) skip_d = 1'b1;
      end
      S_AVAILABLE: begin
        if (beat) skip_d = 1'b1;
        if (i_dispatch_packet_read_discard) begin
          state_d = S_EMPTY;
        end else if (i_dispatch_fifo_rd_en && rd_ptr < count) begin
          rd_ptr_d = rd_ptr_inc;
          mem_re   = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    if (strobe) begin
      if (skip_d) begin
        skip_d = 1'b0;
        drop   = 1'b1;
      end else if (state_d == S_WRITE) begin
        if (i_mac_rx_good) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_EMPTY;
          drop    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      state     <= S_EMPTY;
      skip      <= 1'b0;
      counter   <= '0;
      count     <= '0;
      rd_ptr    <= '0;
      last_mask <= '0;
      rd_data   <= '0;
    end else begin
      state     <= state_d;
      skip      <= skip_d;
      counter   <= counter + {31'd0, drop};
      count     <= count_d;
      rd_ptr    <= rd_ptr_d;
      last_mask <= last_mask_d;
      if (mem_re) rd_data <= mem[mem_raddr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_waddr] <= i_mac_rx_data;
  end

  assign rd_next = {1'b0, rd_ptr} + {{(ADDR_WIDTH+1){1'b0}}, i_dispatch_fifo_rd_en};

  assign o_dispatch_packet_available = (state == S_AVAILABLE);
  assign o_dispatch_data_valid       = (state == S_AVAILABLE) ? last_mask : 8'h00;
  assign o_dispatch_fifo_empty       = (state == S_AVAILABLE) ? (rd_next >= {1'b0, count}) : 1'b1;
  assign o_dispatch_fifo_rd_data     = rd_data;
  assign o_dropped_packets           = counter;

endmodule
